// File: rtl/io_unit.sv
// Port-mapped I/O: 4 captured input ports, 4 FIFO-backed output ports.
// Optional IO_IRQ_EN adds an irq mask register at port 5 and a registered irq.
module io_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we_out,
    input  logic               re_in,
    input  logic [2:0]         port_sel,
    input  logic [WIDTH-1:0]   wdata,
    output logic [WIDTH-1:0]   rdata,
    input  logic [4*WIDTH-1:0] in_data,
    input  logic [3:0]         in_valid,
    output logic [3:0]         in_ack,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic               irq
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] hold [4];
    logic [WIDTH-1:0] mem [4][DEPTH];
    logic [AW-1:0]    rd_ptr [4];
    logic [AW-1:0]    wr_ptr [4];
    logic [CW-1:0]    count [4];

    logic [3:0] in_full, in_full_next, cap, rd_hit, wr_hit;
    logic [3:0] ovf, ovf_set, push, pop, out_full, ack;
    logic [3:0] mask;
    logic       ovf_rd;

    always_comb begin
        for (int p = 0; p < 4; p++) begin
            rd_hit[p]       = re_in && (port_sel == 3'(p));
            wr_hit[p]       = we_out && (port_sel == 3'(p));
            cap[p]          = in_valid[p] && !in_full[p];
            in_full_next[p] = cap[p] | (in_full[p] & ~rd_hit[p]);
            out_full[p]     = (count[p] == CW'(DEPTH));
            pop[p]          = (count[p] != '0) && out_ready[p];
            // A full FIFO still accepts the byte when its head leaves this cycle
            push[p]         = wr_hit[p] && (!out_full[p] || pop[p]);
            ovf_set[p]      = wr_hit[p] && !push[p];
        end
    end

    assign ovf_rd = re_in && (port_sel == 3'd6);
    assign in_ack = ack;

    always_comb begin
        out_data = '0;
        out_valid = '0;
        for (int p = 0; p < 4; p++) begin
            out_data[p*WIDTH +: WIDTH] = mem[p][rd_ptr[p]];
            out_valid[p] = (count[p] != '0);
        end
    end

    always_comb begin
        rdata = '0;
        if (re_in) begin
            case (port_sel)
                3'd0, 3'd1, 3'd2, 3'd3:
                    rdata = in_full[port_sel[1:0]] ? hold[port_sel[1:0]] : '0;
                3'd4: rdata = WIDTH'({out_full, in_full});
                3'd5: rdata = WIDTH'(mask);
                3'd6: rdata = WIDTH'(ovf);
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_full <= '0;
            ack     <= '0;
            ovf     <= '0;
            for (int p = 0; p < 4; p++) begin
                count[p]  <= '0;
                rd_ptr[p] <= '0;
                wr_ptr[p] <= '0;
            end
        end else begin
            in_full <= in_full_next;
            ack     <= cap;
            // A fresh overflow outranks the read-to-clear
            ovf     <= (ovf & ~{4{ovf_rd}}) | ovf_set;
            for (int p = 0; p < 4; p++) begin
                if (push[p])
                    wr_ptr[p] <= wr_ptr[p] + 1'b1;
                if (pop[p])
                    rd_ptr[p] <= rd_ptr[p] + 1'b1;
                count[p] <= count[p] + CW'(push[p]) - CW'(pop[p]);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 4; p++) begin
            if (cap[p])
                hold[p] <= in_data[p*WIDTH +: WIDTH];
            if (push[p])
                mem[p][wr_ptr[p]] <= wdata;
        end
    end

`ifdef IO_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            mask  <= '0;
            irq_q <= 1'b0;
        end else begin
            if (we_out && (port_sel == 3'd5))
                mask <= wdata[3:0];
            irq_q <= |(in_full_next & mask);
        end
    end

    assign irq = irq_q;
`else
    assign mask = 4'd0;
    assign irq  = 1'b0;
`endif

endmodule

// File: tb/tb_io_unit.sv
// Directed bench for io_unit: reset, capture, output FIFO, overflow, irq.
module tb_io_unit;
    localparam int WIDTH = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               we_out;
    logic               re_in;
    logic [2:0]         port_sel;
    logic [WIDTH-1:0]   wdata;
    logic [WIDTH-1:0]   rdata;
    logic [4*WIDTH-1:0] in_data;
    logic [3:0]         in_valid;
    logic [3:0]         in_ack;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic               irq;

    int vectors = 0;
    int errors  = 0;

    io_unit #(.WIDTH(WIDTH), .DEPTH(2)) dut (
        .clk(clk),
        .reset(reset),
        .we_out(we_out),
        .re_in(re_in),
        .port_sel(port_sel),
        .wdata(wdata),
        .rdata(rdata),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ack(in_ack),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [2:0] sel);
        re_in = 1'b1;
        port_sel = sel;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        we_out = 1'b0;
        re_in = 1'b0;
        port_sel = 3'd0;
        wdata = '0;
        in_data = 32'hDEADBEEF;
        in_valid = 4'hF;
        out_ready = 4'h0;

        // Reset held two cycles with all inputs presenting data
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ack", 32'(in_ack), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_rdata_idle", 32'(rdata), 32'h0);
        rd(3'd4);
        chk("rst_status", 32'(rdata), 32'h00);
        re_in = 1'b0;
        in_valid = 4'h0;
        tick();
        reset = 1'b1;
        tick();

        // Capture on port 1
        in_data[1*WIDTH +: WIDTH] = 8'hA5;
        in_valid = 4'b0010;
        tick();
        chk("cap_ack_pulse", 32'(in_ack), 32'h2);
        in_valid = 4'b0000;
        rd(3'd4);
        chk("cap_status", 32'(rdata), 32'h02);
        tick();
        chk("cap_ack_drop", 32'(in_ack), 32'h0);
        rd(3'd1);
        chk("in_port1", 32'(rdata), 32'hA5);
        tick();
        rd(3'd4);
        chk("cap_status_clr", 32'(rdata), 32'h00);
        rd(3'd1);
        chk("in_port1_empty", 32'(rdata), 32'h00);
        re_in = 1'b0;

        // Three writes into a 2-deep FIFO with the device stalled
        we_out = 1'b1;
        port_sel = 3'd0;
        wdata = 8'h11;
        tick();
        chk("push_vld_next", 32'(out_valid[0]), 32'h1);
        wdata = 8'h22;
        tick();
        wdata = 8'h33;
        tick();
        we_out = 1'b0;
        chk("fifo_head", 32'(out_data[7:0]), 32'h11);
        rd(3'd4);
        chk("fifo_full_status", 32'(rdata), 32'h10);
        rd(3'd6);
        chk("ovf_set", 32'(rdata), 32'h01);
        tick();
        chk("ovf_clr", 32'(rdata), 32'h00);
        re_in = 1'b0;
        out_ready = 4'b0001;
        tick();
        chk("drain_second", 32'(out_data[7:0]), 32'h22);
        tick();
        chk("drain_empty", 32'(out_valid[0]), 32'h0);
        out_ready = 4'b0000;

        // Full FIFO, write and pop in the same cycle
        we_out = 1'b1;
        port_sel = 3'd0;
        wdata = 8'h11;
        tick();
        wdata = 8'h22;
        tick();
        wdata = 8'h44;
        out_ready = 4'b0001;
        tick();
        we_out = 1'b0;
        out_ready = 4'b0000;
        rd(3'd6);
        chk("pushpop_no_ovf", 32'(rdata), 32'h00);
        rd(3'd4);
        chk("pushpop_still_full", 32'(rdata), 32'h10);
        chk("pushpop_head", 32'(out_data[7:0]), 32'h22);
        re_in = 1'b0;
        out_ready = 4'b0001;
        tick();
        chk("pushpop_next", 32'(out_data[7:0]), 32'h44);
        tick();
        chk("pushpop_empty", 32'(out_valid), 32'h0);
        out_ready = 4'b0000;

        // Writes to status and unmapped ports are ignored
        we_out = 1'b1;
        wdata = 8'hFF;
        port_sel = 3'd4;
        tick();
        port_sel = 3'd7;
        tick();
        we_out = 1'b0;
        rd(3'd4);
        chk("wr4_ignored", 32'(rdata), 32'h00);
        rd(3'd7);
        chk("port7_zero", 32'(rdata), 32'h00);
        re_in = 1'b0;

        // Read of a full input port while a new byte waits
        in_data[2*WIDTH +: WIDTH] = 8'h3C;
        in_valid = 4'b0100;
        tick();
        in_valid = 4'b0000;
        tick();
        in_data[2*WIDTH +: WIDTH] = 8'h5C;
        in_valid = 4'b0100;
        rd(3'd2);
        chk("full_read_old", 32'(rdata), 32'h3C);
        tick();
        re_in = 1'b0;
        chk("full_gap_no_ack", 32'(in_ack), 32'h0);
        tick();
        chk("full_late_ack", 32'(in_ack), 32'h4);
        in_valid = 4'b0000;
        rd(3'd2);
        chk("full_new_byte", 32'(rdata), 32'h5C);
        tick();
        re_in = 1'b0;

`ifdef IO_IRQ_EN
        we_out = 1'b1;
        port_sel = 3'd5;
        wdata = 8'h08;
        tick();
        we_out = 1'b0;
        rd(3'd5);
        chk("mask_read", 32'(rdata), 32'h08);
        re_in = 1'b0;
        in_data[3*WIDTH +: WIDTH] = 8'h77;
        in_valid = 4'b1000;
        tick();
        in_valid = 4'b0000;
        chk("irq_rise", 32'(irq), 32'h1);
        rd(3'd3);
        chk("irq_port3", 32'(rdata), 32'h77);
        tick();
        re_in = 1'b0;
        chk("irq_fall", 32'(irq), 32'h0);
        in_data[0 +: WIDTH] = 8'h12;
        in_valid = 4'b0001;
        tick();
        in_valid = 4'b0000;
        tick();
        chk("irq_masked", 32'(irq), 32'h0);
        rd(3'd0);
        tick();
        re_in = 1'b0;
`else
        we_out = 1'b1;
        port_sel = 3'd5;
        wdata = 8'hFF;
        tick();
        we_out = 1'b0;
        rd(3'd5);
        chk("no_mask_read", 32'(rdata), 32'h00);
        re_in = 1'b0;
        in_data[3*WIDTH +: WIDTH] = 8'h77;
        in_valid = 4'b1000;
        tick();
        in_valid = 4'b0000;
        tick();
        chk("no_irq", 32'(irq), 32'h0);
        rd(3'd3);
        tick();
        re_in = 1'b0;
`endif

        // Reset mid-transfer discards pending data
        we_out = 1'b1;
        port_sel = 3'd1;
        wdata = 8'h99;
        in_valid = 4'b0001;
        tick();
        we_out = 1'b0;
        in_valid = 4'b0000;
        chk("pre_rst_valid", 32'(out_valid), 32'h2);
        reset = 1'b0;
        in_valid = 4'b0001;
        tick();
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_no_ack", 32'(in_ack), 32'h0);
        rd(3'd4);
        chk("mid_rst_status", 32'(rdata), 32'h00);
        re_in = 1'b0;
        in_valid = 4'b0000;
        reset = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
